// File: rtl/countdown_pkg.sv
// ---------------------------------------------------------------------------
// countdown_pkg
// Purpose : shared definitions for the countdown timer slice.
//           Holds the FSM state encoding and the default counter width.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package countdown_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : countdown_pkg

// File: rtl/countdown_timer_if.sv
// ---------------------------------------------------------------------------
// countdown_timer_if
// Purpose : groups the control and status signals of countdown_timer.
// Signals : load        - load request, sampled each rising edge
//           load_val    - start value captured when load is high
//           en          - count enable (low pauses the countdown)
//           auto_reload - restart from the stored value on expiry
//           count       - current count value (registered)
//           busy        - high while the timer is running (registered)
//           done        - one-cycle expiry pulse (registered)
// Modports: master drives the controls, slave (the timer) drives status.
// ---------------------------------------------------------------------------
interface countdown_timer_if
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, en, auto_reload,
        input  count, busy, done
    );

    modport slave (
        input  load, load_val, en, auto_reload,
        output count, busy, done
    );

endinterface : countdown_timer_if

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
// Purpose : loadable down-counter with pause, one-shot or auto-reload mode
//           and a registered one-cycle expiry pulse.
// Ports   : clk - system clock, all state updates on the rising edge
//           clr - synchronous active-high reset
//           bus - countdown_timer_if.slave (load, load_val, en, auto_reload
//                 in; count, busy, done out)
// Priority each edge: clr > load > decrement/expiry > hold.
// WIDTH must match the WIDTH of the connected interface instance (2..32).
// ---------------------------------------------------------------------------
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    countdown_timer_if.slave   bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             expiry;

    // Expiry is detected one step early (count==1) so that the cycle showing
    // count==0 (or the reloaded value) is also the cycle showing done.
    assign expiry = (count_q == ONE);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (bus.load) begin
            // A load always wins over expiry, so a coincident expiry pulse is
            // dropped and the timer restarts from the new value.
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            if (bus.load_val != '0) begin
                state_d = RUN;
                busy_d  = 1'b1;
            end else begin
                // Loading zero is an immediate expiry.
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else if (state_q == RUN && bus.en) begin
            if (expiry) begin
                done_d = 1'b1;
                if (bus.auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end else if (count_q == '0) begin
                // Unreachable in normal operation (RUN is entered only with a
                // nonzero value); recover to IDLE rather than wrap.
                state_d = IDLE;
                busy_d  = 1'b0;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
// Purpose : directed self-checking bench for countdown_timer (WIDTH=4).
// ---------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int WIDTH = 4;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;
    int   done_seen;
    int   cycles;

    countdown_timer_if #(.WIDTH(WIDTH)) bus ();

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One clock edge; inputs and samples happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int exp_count, input int exp_busy, input int exp_done);
        check({tag, ".count"}, 32'(bus.count), 32'(exp_count));
        check({tag, ".busy"},  32'(bus.busy),  32'(exp_busy));
        check({tag, ".done"},  32'(bus.done),  32'(exp_done));
        $display("txn %-14s count=%0d busy=%0b done=%0b", tag, bus.count, bus.busy, bus.done);
    endtask

    task automatic do_load(input int val);
        bus.load     = 1'b1;
        bus.load_val = WIDTH'(val);
        step();
        bus.load     = 1'b0;
    endtask

    initial begin
        int exp_ar[9];
        int exp_dn[9];
        n_checks = 0;
        n_fail   = 0;

        // Reset held while a load is requested.
        clr             = 1'b1;
        bus.load        = 1'b1;
        bus.load_val    = 4'd7;
        bus.en          = 1'b1;
        bus.auto_reload = 1'b0;
        step();
        check_out("clr1", 0, 0, 0);
        step();
        check_out("clr2", 0, 0, 0);
        clr      = 1'b0;
        bus.load = 1'b0;

        // One-shot countdown from 5.
        do_load(5);
        check_out("os_load5", 5, 1, 0);
        for (int v = 4; v >= 1; v--) begin
            step();
            check_out("os_dec", v, 1, 0);
        end
        step();
        check_out("os_expire", 0, 0, 1);
        bus.auto_reload = 1'b1;  // ignored in IDLE
        step();
        check_out("os_idle", 0, 0, 0);
        step();
        check_out("os_idle2", 0, 0, 0);
        bus.auto_reload = 1'b0;

        // Pause: load 6, run to 3, hold 3 cycles, then finish.
        done_seen = 0;
        do_load(6);
        check_out("ps_load6", 6, 1, 0);
        for (int v = 5; v >= 3; v--) begin
            step();
            done_seen += int'(bus.done);
            check_out("ps_dec", v, 1, 0);
        end
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            done_seen += int'(bus.done);
            check_out("ps_hold", 3, 1, 0);
        end
        bus.en = 1'b1;
        step();
        done_seen += int'(bus.done);
        check_out("ps_res2", 2, 1, 0);
        step();
        done_seen += int'(bus.done);
        check_out("ps_res1", 1, 1, 0);
        step();
        done_seen += int'(bus.done);
        check_out("ps_res0", 0, 0, 1);
        step();
        done_seen += int'(bus.done);
        check("ps_done_total", 32'(done_seen), 32'd1);

        // Auto-reload from 3 over 9 cycles.
        exp_ar = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
        exp_dn = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
        bus.auto_reload = 1'b1;
        do_load(3);
        check_out("ar_c0", exp_ar[0], 1, exp_dn[0]);
        for (int i = 1; i < 9; i++) begin
            step();
            check_out($sformatf("ar_c%0d", i), exp_ar[i], 1, exp_dn[i]);
        end

        // Auto-reload with value 1: done every enabled cycle, count never 0.
        do_load(1);
        check_out("ar1_load", 1, 1, 0);
        step();
        check_out("ar1_a", 1, 1, 1);
        step();
        check_out("ar1_b", 1, 1, 1);
        bus.auto_reload = 1'b0;
        step();
        check_out("ar1_stop", 0, 0, 1);

        // Reload at count=2, then load coinciding with expiry.
        do_load(5);
        step();
        step();
        step();
        check_out("rl_at2", 2, 1, 0);
        do_load(9);
        check_out("rl_load9", 9, 1, 0);
        for (int i = 0; i < 7; i++) step();
        check_out("rl_at2b", 2, 1, 0);
        step();
        check_out("rl_at1", 1, 1, 0);
        do_load(7);
        check_out("rl_expload", 7, 1, 0);

        // Load 0 while running -> immediate done, IDLE.
        do_load(0);
        check_out("ld0", 0, 0, 1);
        step();
        check_out("ld0_after", 0, 0, 0);
        do_load(0);
        check_out("ld0_idle", 0, 0, 1);
        step();
        check_out("ld0_idle_after", 0, 0, 0);

        // Load 15 -> done after exactly 15 enabled cycles.
        do_load(15);
        check_out("ld15", 15, 1, 0);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
        check("ld15_cycles", 32'(cycles), 32'd15);
        check("ld15_count", 32'(bus.count), 32'd0);

        // clr mid-run overrides a same-cycle load; no done follows.
        do_load(6);
        step();
        step();
        check_out("cl_at4", 4, 1, 0);
        clr          = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'd8;
        step();
        clr      = 1'b0;
        bus.load = 1'b0;
        check_out("cl_abort", 0, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            done_seen += int'(bus.done);
        end
        check("cl_no_done", 32'(done_seen), 32'd0);
        check("cl_count", 32'(bus.count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_countdown_timer

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 load  input  1  load request; sampled each rising edge.
REQ-005 load_val  input  WIDTH  start value captured when load is sampled high.
REQ-006 en  input  1  count enable; low pauses countdown, count held.
REQ-007 auto_reload  input  1  high: restart from stored value on expiry; low: stop on expiry.
REQ-008 count  output  WIDTH  current count value, registered.
REQ-009 busy  output  1  high while in RUN state, registered.
REQ-010 done  output  1  one-cycle expiry pulse, registered.

Function
REQ-011 States SHALL be IDLE and RUN only; state, count, busy, done and the reload register SHALL all be flops.
REQ-012 Priority each edge SHALL be clr > load > decrement/expiry > hold.
REQ-013 load=1 with load_val!=0, any state: count<=load_val, reload register<=load_val, state<=RUN, busy<=1, done<=0, next edge.
REQ-014 load=1 with load_val==0: count<=0, reload register<=0, state<=IDLE, busy<=0, done<=1 for one cycle.
REQ-015 RUN, en=1, count>1: count<=count-1, done<=0.
REQ-016 RUN, en=1, count==1, auto_reload=0: count<=0, state<=IDLE, busy<=0, done<=1; done and count==0 SHALL first appear on the same cycle.
REQ-017 RUN, en=1, count==1, auto_reload=1: count<=reload register, stay RUN, done<=1; the value 0 SHALL NOT appear on count; period = reload value cycles.
REQ-018 RUN, en=0: count, state, busy held; done<=0.
REQ-019 IDLE without load: count held at 0, busy=0, done<=0; en and auto_reload ignored.
REQ-020 load coinciding with expiry SHALL suppress done and restart from new load_val.
REQ-021 auto_reload sampled only on the expiry edge; changing it mid-run SHALL have no other effect.
REQ-022 done SHALL never be high two consecutive cycles except with auto_reload=1 and reload value 1 (done high every enabled cycle).
REQ-023 Decrement SHALL be modulo-free: count never underflows below 0 and never wraps to 2^WIDTH-1.

Reset
REQ-024 clr=1 at an edge: state<=IDLE, count<=0, busy<=0, done<=0, reload register<=0; load, en same cycle ignored.
REQ-025 clr asserted mid-RUN SHALL abort without a done pulse.
REQ-026 Outputs before the first clr edge are undefined; bench SHALL apply clr for at least 2 cycles.

Structure
REQ-027 Shared package countdown_pkg SHALL hold the state encoding (IDLE=1'b0, RUN=1'b1) and the default WIDTH constant.
REQ-028 Single flat module; no sub-module; one sequential block for state/count/flags, expiry detect (count==1) combinational.
REQ-029 Expected size 120-250 lines of RTL.

Verification (WIDTH=4)
REQ-030 clr=1 for 2 cycles from power-up -> count=0, busy=0, done=0; held while clr=1 even with load=1, load_val=7.
REQ-031 load 5, en=1, auto_reload=0 -> count 5,4,3,2,1,0 on successive cycles; done=1 and busy=0 exactly on the count=0 cycle; count stays 0 afterwards.
REQ-032 load 6, en=1 until count=3, en=0 for 3 cycles, en=1 -> count 3,3,3,3 then 2,1,0; exactly one done pulse total.
REQ-033 load 3, en=1, auto_reload=1 for 9 cycles -> count 3,2,1,3,2,1,3,2,1; done high on each cycle count returns to 3; busy never falls.
REQ-034 load 9 while running at count=2 -> next cycle count=9, no done; load 0 in IDLE -> count=0, done one cycle, busy=0; load 15 -> 15 enabled cycles to done.
REQ-035 clr=1 at count=4 in RUN with load=1, load_val=8 same cycle -> next cycle count=0, busy=0, done=0, and no done pulse follows.
